btn_in_rpt: RTL
===============

Name: btn_in_rpt

Overview:
- Parametrised successor to the board-level key/switch input conditioner.
- Samples N_KEY push-buttons and N_SW slide switches at a divided tick rate, with a 2-FF synchroniser per input.
- Emits single-cycle press pulses, auto-repeat pulses with configurable delay and rate, held levels, and a debounced switch bus with a change strobe.
- Sits between board pins and the CPU/peripheral I/O registers.

Parameters:
- N_KEY, 4, number of push-button inputs.
- N_SW, 10, number of slide-switch inputs.
- TICK_DIV, 1250000, clocks per sample tick (40 Hz at 50 MHz); minimum 2.
- REPEAT_DELAY, 20, ticks from press detection to first repeat pulse; minimum 1.
- REPEAT_RATE, 4, ticks between subsequent repeat pulses; minimum 1.
- KEY_ACTIVE_LOW, 1, 1 = key pin reads 0 when pressed.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- KEY  in  N_KEY  raw key pins.
- SW  in  N_SW  raw switch pins, 1 = on.
- KEYOUT  out  N_KEY  one-cycle pulse per press.
- KEYREP  out  N_KEY  one-cycle pulse on press and on each auto-repeat.
- KEYHELD  out  N_KEY  level, debounced key pressed.
- SWOUT  out  N_SW  debounced switch state.
- SWCHG  out  1  one-cycle pulse when SWOUT changes.

Behaviour:
- Reset: all outputs 0. Tick counter 0. FSMs IDLE. Key sample registers hold the released level (all 1 if KEY_ACTIVE_LOW). Switch sample registers 0.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick = (cnt == TICK_DIV-1), high for exactly 1 clock.
- Synchroniser: every clock, 2 FFs per KEY/SW bit. Keys are normalised to pressed = 1 after sync.
- Sampling: on tick, s2 <= s1 and s1 <= sync. Edges between ticks are invisible, so bounce shorter than one tick period is rejected.
- Press event: on tick, pre-update s1 pressed and s2 released. KEYOUT and KEYREP go high the following clock, for 1 clock.
- Per-key FSM, repeat counter rc (width clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)):
  - IDLE: on press event -> DELAY, rc = 0.
  - DELAY: on tick, if s1 released -> IDLE. Else rc++. When rc reaches REPEAT_DELAY-1 -> REPEAT, rc = 0, KEYREP pulse.
  - REPEAT: on tick, if s1 released -> IDLE. Else rc++. When rc reaches REPEAT_RATE-1 -> rc = 0, KEYREP pulse.
  - Release takes priority over a repeat pulse on the same tick.
- KEYHELD = 1 in DELAY or REPEAT.
- Keys are fully independent. Simultaneous presses on several keys produce simultaneous pulses.
- SWOUT <= s2 (switch) each clock. SWCHG = 1 for the one clock in which the new SWOUT differs from the old.
- Asynchronous reset mid-operation clears everything immediately. A key still held after reset release is detected as a fresh press: exactly one KEYOUT pulse, two ticks later.
- Output latency from a clean pin edge to KEYOUT: 2 sync clocks + 2 tick boundaries + 1 clock, i.e. at most 2*TICK_DIV+3 clocks.

Decomposition:
- Package btn_in_pkg:
  - FSM state enum {IDLE, DELAY, REPEAT}.
  - clog2 constant function.
  - Pressed-level constant derived from KEY_ACTIVE_LOW.
- Sub-module key_rpt_fsm: one key's FSM, rc and pulse generation. Instantiated N_KEY times in a generate loop.
- Tick counter, synchronisers and switch path stay in the top.

Test Plan (TICK_DIV=4, REPEAT_DELAY=3, REPEAT_RATE=2, N_KEY=4, N_SW=10, active-low):
- Reset with KEY=4'hF, SW=0 -> every output 0 for 20 clocks, no pulses.
- KEY[0] low for 3 ticks, then high -> exactly one KEYOUT[0] and one KEYREP[0] pulse, KEYHELD[0] high 3 ticks; other keys stay quiet.
- KEY[1] low for 9 ticks -> KEYREP[1] pulses at detection, +12, +20, +28 clocks (4 total). KEYOUT[1] has exactly 1 pulse. KEYHELD[1] falls one tick after release is sampled.
- KEY[2] glitches low for 2 clocks between ticks, 5 times -> no KEYOUT, KEYREP or KEYHELD activity.
- SW 10'h000 -> 10'h2A5 -> SWOUT = 10'h2A5 within 2*TICK_DIV+3 clocks, SWCHG exactly 1 pulse. SW held steady afterwards -> no further SWCHG.
- Assert RST for 1 clock while KEY[3] is in REPEAT -> all outputs 0 combinationally during reset. After reset, with KEY[3] still held, exactly one new KEYOUT[3] pulse and the repeat cadence restarts from DELAY.

Source files
------------

// File: rtl/btn_in_pkg.sv
// Shared types and constant helpers for the key/switch input conditioner.
//   key_state_e : per-key repeat FSM state
//   clog2       : ceiling log2, never less than 1 (usable as a vector width)
//   max_u       : larger of two unsigned values
//   pressed_lvl : pin level that means "pressed" for a given key polarity
package btn_in_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } key_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 32'd0;
      while ((64'(1) << width) < 64'(value)) width++;
      return (width == 32'd0) ? 32'd1 : width;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic pressed_lvl(input bit active_low);
      return ~active_low;
   endfunction

endpackage

// File: rtl/btn_in_rpt_if.sv
// Board-side bundle of the input conditioner.
//   key     : raw key pins            sw      : raw switch pins (1 = on)
//   keyout  : one-cycle press pulse    keyrep  : press + auto-repeat pulses
//   keyheld : debounced pressed level  swout   : debounced switch state
//   swchg   : one-cycle pulse when swout changes
// master drives the pins and observes the results; slave is the conditioner.
interface btn_in_rpt_if #(
   parameter int unsigned N_KEY = 4,
   parameter int unsigned N_SW  = 10
);
   logic [N_KEY-1:0] key;
   logic [N_SW-1:0]  sw;
   logic [N_KEY-1:0] keyout;
   logic [N_KEY-1:0] keyrep;
   logic [N_KEY-1:0] keyheld;
   logic [N_SW-1:0]  swout;
   logic             swchg;

   modport master (
      output key, sw,
      input  keyout, keyrep, keyheld, swout, swchg
   );

   modport slave (
      input  key, sw,
      output keyout, keyrep, keyheld, swout, swchg
   );
endinterface

// File: rtl/key_rpt_fsm.sv
// One key's press / auto-repeat state machine.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   tick_i         : sample tick, one clock wide
//   s1_pressed_i   : newest tick sample of the key, pressed = 1
//   s2_pressed_i   : previous tick sample of the key, pressed = 1
//   keyout_o       : one-cycle pulse on press detection
//   keyrep_o       : one-cycle pulse on press and on every auto-repeat
//   keyheld_o      : high while the key is considered held
module key_rpt_fsm
   import btn_in_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY = 20,
   parameter int unsigned REPEAT_RATE  = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tick_i,
   input  logic s1_pressed_i,
   input  logic s2_pressed_i,
   output logic keyout_o,
   output logic keyrep_o,
   output logic keyheld_o
);

   localparam int unsigned RC_W = clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 32'd1);
   localparam logic [RC_W-1:0] RC_DELAY_LAST = RC_W'(REPEAT_DELAY - 32'd1);
   localparam logic [RC_W-1:0] RC_RATE_LAST  = RC_W'(REPEAT_RATE - 32'd1);

   key_state_e      state_q, state_d;
   logic [RC_W-1:0] rc_q, rc_d;
   logic            keyout_q, keyout_d;
   logic            keyrep_q, keyrep_d;
   logic            keyheld_q, keyheld_d;

   // State, repeat counter and registered pulse outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rc_q      <= '0;
         keyout_q  <= 1'b0;
         keyrep_q  <= 1'b0;
         keyheld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rc_q      <= rc_d;
         keyout_q  <= keyout_d;
         keyrep_q  <= keyrep_d;
         keyheld_q <= keyheld_d;
      end
   end

   // Next state. rc is compared before it is advanced, so a repeat fires
   // exactly REPEAT_DELAY (then REPEAT_RATE) ticks after the previous pulse.
   // A release seen on a tick wins over a repeat due on that same tick.
   always_comb begin
      state_d  = state_q;
      rc_d     = rc_q;
      keyout_d = 1'b0;
      keyrep_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (tick_i && s1_pressed_i && !s2_pressed_i) begin
               state_d  = DELAY;
               rc_d     = '0;
               keyout_d = 1'b1;
               keyrep_d = 1'b1;
            end
         end
         DELAY: begin
            if (tick_i) begin
               if (!s1_pressed_i) begin
                  state_d = IDLE;
                  rc_d    = '0;
               end else if (rc_q == RC_DELAY_LAST) begin
                  state_d  = REPEAT;
                  rc_d     = '0;
                  keyrep_d = 1'b1;
               end else begin
                  rc_d = rc_q + RC_W'(1);
               end
            end
         end
         REPEAT: begin
            if (tick_i) begin
               if (!s1_pressed_i) begin
                  state_d = IDLE;
                  rc_d    = '0;
               end else if (rc_q == RC_RATE_LAST) begin
                  rc_d     = '0;
                  keyrep_d = 1'b1;
               end else begin
                  rc_d = rc_q + RC_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            rc_d    = '0;
         end
      endcase

      keyheld_d = (state_d != IDLE);
   end

   assign keyout_o  = keyout_q;
   assign keyrep_o  = keyrep_q;
   assign keyheld_o = keyheld_q;

endmodule

// File: rtl/btn_in_rpt.sv
// Key/switch input conditioner: synchronises raw board pins, samples them at
// a divided tick rate (rejecting bounce shorter than one tick) and produces
// press pulses, auto-repeat pulses, held levels and a debounced switch bus.
//   clk_i : system clock
//   rst_i : asynchronous active-high reset
//   bus   : slave side of btn_in_rpt_if (key/sw in; keyout, keyrep,
//           keyheld, swout, swchg out)
module btn_in_rpt
   import btn_in_pkg::*;
#(
   parameter int unsigned N_KEY          = 4,
   parameter int unsigned N_SW           = 10,
   parameter int unsigned TICK_DIV       = 1250000,
   parameter int unsigned REPEAT_DELAY   = 20,
   parameter int unsigned REPEAT_RATE    = 4,
   parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   btn_in_rpt_if.slave bus
);

   localparam int unsigned      CNT_W        = clog2(TICK_DIV);
   localparam logic             PRESSED_LVL  = pressed_lvl(KEY_ACTIVE_LOW);
   localparam logic [N_KEY-1:0] KEY_PRESSED  = {N_KEY{PRESSED_LVL}};
   localparam logic [N_KEY-1:0] KEY_RELEASED = {N_KEY{~PRESSED_LVL}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_c;

   // Key samples keep raw pin polarity; they are normalised at the FSM input.
   logic [N_KEY-1:0] key_meta_q, key_sync_q, key_s1_q, key_s2_q;
   logic [N_KEY-1:0] key_s1_pr_c, key_s2_pr_c;
   logic [N_SW-1:0]  sw_meta_q, sw_sync_q, sw_s1_q, sw_s2_q;
   logic [N_SW-1:0]  swout_q;
   logic             swchg_q;

   logic [N_KEY-1:0] keyout, keyrep, keyheld;

   // Sample tick divider.
   always_comb begin
      tick_c = (cnt_q == CNT_W'(TICK_DIV - 32'd1));
      cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Key synchroniser and two-deep tick sampler.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         key_meta_q <= KEY_RELEASED;
         key_sync_q <= KEY_RELEASED;
         key_s1_q   <= KEY_RELEASED;
         key_s2_q   <= KEY_RELEASED;
      end else begin
         key_meta_q <= bus.key;
         key_sync_q <= key_meta_q;
         if (tick_c) begin
            key_s2_q <= key_s1_q;
            key_s1_q <= key_sync_q;
         end
      end
   end

   // Pressed = 1 regardless of pin polarity.
   always_comb begin
      key_s1_pr_c = ~(key_s1_q ^ KEY_PRESSED);
      key_s2_pr_c = ~(key_s2_q ^ KEY_PRESSED);
   end

   // Switch synchroniser, tick sampler, debounced output and change strobe.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         sw_s1_q   <= '0;
         sw_s2_q   <= '0;
         swout_q   <= '0;
         swchg_q   <= 1'b0;
      end else begin
         sw_meta_q <= bus.sw;
         sw_sync_q <= sw_meta_q;
         if (tick_c) begin
            sw_s2_q <= sw_s1_q;
            sw_s1_q <= sw_sync_q;
         end
         swout_q <= sw_s2_q;
         swchg_q <= (sw_s2_q != swout_q);
      end
   end

   // One independent repeat FSM per key.
   for (genvar g = 0; g < N_KEY; g++) begin : g_key
      key_rpt_fsm #(
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_fsm (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .tick_i       (tick_c),
         .s1_pressed_i (key_s1_pr_c[g]),
         .s2_pressed_i (key_s2_pr_c[g]),
         .keyout_o     (keyout[g]),
         .keyrep_o     (keyrep[g]),
         .keyheld_o    (keyheld[g])
      );
   end

   assign bus.keyout  = keyout;
   assign bus.keyrep  = keyrep;
   assign bus.keyheld = keyheld;
   assign bus.swout   = swout_q;
   assign bus.swchg   = swchg_q;

endmodule
